lut_table_sync: RTL and testbench
=================================

# lut_table_sync

Clocked, parametrised successor to the combinational LUT tables used by the SR-LUT accelerator. It stores ENTRIES entries, each WORDS words of DW bits (packed int8 lanes). It provides three ports: a one-cycle entry write port, a pipelined entry read port with valid/ready backpressure, and a word-serial bulk loader FSM for filling the whole table from a stream. It sits between the LUT weight loader (DMA side) and the interpolation datapath that fetches one entry per pixel per cycle.

## Interface
- ENTRIES, 36, number of entries; legal base range 0..ENTRIES-1
- WORDS, 4, DW-bit words per entry
- DW, 32, word width (4 x int8)
- AW, $clog2(ENTRIES), base address width
- clk  in  1  rising-edge clock; one clock domain
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write one entry this cycle
- wr_base  in  AW  entry index for write
- wr_data  in  DW x [0:WORDS-1]  entry write data, word 0 first
- rd_req  in  1  read request valid
- rd_base  in  AW  entry index for read
- rd_gnt  out  1  read request accepted this cycle (combinational)
- rd_valid  out  1  rd_data holds a completed read
- rd_ready  in  1  consumer accepts rd_data
- rd_data  out  DW x [0:WORDS-1]  read entry
- ld_start  in  1  begin bulk load (pulse)
- ld_valid  in  1  ld_data word valid
- ld_data  in  DW  bulk-load word, flat order entry*WORDS+word
- ld_ready  out  1  loader accepts ld_data this cycle
- ld_busy  out  1  loader in LOAD state
- ld_done  out  1  one-cycle pulse after last word written
- err_oob  out  1  one-cycle pulse: out-of-range access seen
- wr_drop  out  1  one-cycle pulse: wr_en discarded (loader busy)

## Operation
- Storage is not touched by rst. Contents are undefined until written.
- Write: if wr_en, wr_base<ENTRIES and !ld_busy, all WORDS words are written at the clock edge. If wr_base>=ENTRIES, the write is ignored and err_oob pulses next cycle. If ld_busy, the write is ignored and wr_drop pulses next cycle.
- Read acceptance: rd_gnt = rd_req && !ld_busy && !(rd_valid && !rd_ready && s1_valid). Stage 1 (s1) registers the memory read. Stage 2 is the rd_data output register.
- Same-cycle wr_en and accepted rd_req to the same valid base: the read returns the new wr_data (write-first bypass). A write landing after acceptance is not seen by that read.
- Out-of-range read: the request is accepted, the read returns all zeros, and err_oob pulses next cycle. A simultaneous oob read and oob write gives a single err_oob pulse.
- Loader FSM states IDLE, LOAD, DONE:
  - IDLE -> LOAD on ld_start; the word counter cnt clears to 0.
  - In LOAD: ld_ready=1. Each ld_valid writes ld_data to word cnt%WORDS of entry cnt/WORDS, then cnt increments.
  - LOAD -> DONE on the write of word ENTRIES*WORDS-1.
  - DONE -> IDLE unconditionally. ld_done=1 while in DONE.
- ld_start outside IDLE is ignored. Reads already in s1/stage 2 when LOAD begins drain normally. No new reads are granted until IDLE.
- Reset mid-load returns the FSM to IDLE with cnt=0. Words already written are retained.

## Timing
- Reset values: rd_valid=0, rd_data=0, ld_busy=0, ld_ready=0, ld_done=0, err_oob=0, wr_drop=0, FSM=IDLE, cnt=0, s1_valid=0.
- Write latency 1: data is readable by a request accepted on the next cycle, and by the same cycle via bypass.
- Read latency 2: request accepted at edge N, rd_valid=1 after edge N+2.
- Throughput: 1 entry/cycle with rd_ready held high.
- Backpressure: while rd_valid && !rd_ready, rd_data and rd_valid hold stable. s1 holds if occupied, and rd_gnt drops only when both stages are full. No data is lost or duplicated.
- Bulk load takes ENTRIES*WORDS accepted beats, with gaps allowed. ld_done rises the cycle after the last beat.
- ld_busy=1 exactly while the FSM is in LOAD.

## Test plan
- Write base 1 = {01FE0000, 02FFFFFB, FFFB0001, FF00FF00}, then read base 1 -> rd_valid 2 cycles after grant with identical words.
- Same-cycle write base 5 = {AAAAAAAA x4} with a read of base 5 -> returns AAAAAAAA x4. A back-to-back read of base 6 returns the old contents.
- Stream reads of bases 0..35 with rd_ready toggling 1,0,0,1 -> 36 responses in order, no loss or duplicates, rd_data stable while stalled.
- Bulk load of 144 words, value = index, with random ld_valid gaps -> ld_done pulses once. Entry 35 word 3 reads 0x8F. wr_en issued mid-load -> wr_drop pulse and no write.
- Read and write of base 36 (ENTRIES=36) -> read returns zeros, single err_oob pulse, memory unchanged.
- Assert rst after 50 load beats, then re-run the full load -> FSM in IDLE and all outputs at reset values after the reset; correct final contents after the re-run.

Source files
------------

// File: rtl/lut_table_sync.sv
`default_nettype none
// ============================================================================
// Module   : lut_table_sync
// Purpose  : Clocked LUT entry table for the SR-LUT accelerator. ENTRIES
//            entries of WORDS x DW-bit words. One-cycle entry write port,
//            two-stage read pipeline with valid/ready backpressure and a
//            word-serial bulk loader FSM.
//            Packed entry layout: word w occupies bits [w*DW +: DW]
//            (word 0 in the least significant bits).
// Revision : 1.0 - initial release
// ============================================================================
module lut_table_sync #(
    parameter int ENTRIES = 36,
    parameter int WORDS   = 4,
    parameter int DW      = 32,
    parameter int AW      = $clog2(ENTRIES)
) (
    input  logic                  clk,
    input  logic                  rst,
    // entry write port
    input  logic                  i_wr_en,
    input  logic [AW-1:0]         i_wr_base,
    input  logic [WORDS*DW-1:0]   i_wr_data,
    // entry read port
    input  logic                  i_rd_req,
    input  logic [AW-1:0]         i_rd_base,
    output logic                  o_rd_gnt,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [WORDS*DW-1:0]   o_rd_data,
    // bulk loader
    input  logic                  i_ld_start,
    input  logic                  i_ld_valid,
    input  logic [DW-1:0]         i_ld_data,
    output logic                  o_ld_ready,
    output logic                  o_ld_busy,
    output logic                  o_ld_done,
    // status pulses
    output logic                  o_err_oob,
    output logic                  o_wr_drop
);

    localparam int              c_WW         = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [AW:0]     c_ENTRIES    = ENTRIES[AW:0];
    localparam logic [AW-1:0]   c_LAST_ENTRY = AW'(ENTRIES - 1);
    localparam logic [c_WW-1:0] c_LAST_WORD  = c_WW'(WORDS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // Storage: deliberately outside the reset domain.
    logic [DW-1:0]        r_mem [ENTRIES][WORDS];

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [AW-1:0]        r_ld_entry;
    logic [c_WW-1:0]      r_ld_word;

    logic                 r_s1_valid;
    logic [WORDS*DW-1:0]  r_s1_data;
    logic                 r_rd_valid;
    logic [WORDS*DW-1:0]  r_rd_data;
    logic                 r_err_oob;
    logic                 r_wr_drop;

    logic                 w_wr_oob;
    logic                 w_rd_oob;
    logic                 w_wr_ok;
    logic                 w_ld_beat;
    logic                 w_ld_last;
    logic                 w_s2_free;
    logic [WORDS*DW-1:0]  w_rd_entry;

    assign w_wr_oob  = ({1'b0, i_wr_base} >= c_ENTRIES);
    assign w_rd_oob  = ({1'b0, i_rd_base} >= c_ENTRIES);
    assign w_wr_ok   = i_wr_en && !w_wr_oob && !o_ld_busy;
    assign w_ld_beat = (r_state == c_LOAD) && i_ld_valid;
    assign w_ld_last = w_ld_beat && (r_ld_entry == c_LAST_ENTRY) && (r_ld_word == c_LAST_WORD);

    // Stage 2 can take a new entry when empty or being consumed this cycle.
    assign w_s2_free = !r_rd_valid || i_rd_ready;
    // Refuse only when both pipeline stages are full and the output is stalled.
    assign o_rd_gnt  = i_rd_req && !o_ld_busy && !(r_rd_valid && !i_rd_ready && r_s1_valid);

    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;
    assign o_err_oob  = r_err_oob;
    assign o_wr_drop  = r_wr_drop;

    // Storage update: loader beats and entry writes are mutually exclusive (writes need !busy).
    always_ff @(posedge clk) begin
        if (w_ld_beat) begin
            r_mem[r_ld_entry][r_ld_word] <= i_ld_data;
        end else if (w_wr_ok) begin
            for (int w = 0; w < WORDS; w++) begin
                r_mem[i_wr_base][w] <= i_wr_data[w*DW +: DW];
            end
        end
    end

    // Read-side entry selection with write-first bypass; out-of-range reads return zeros.
    always_comb begin
        w_rd_entry = '0;
        if (!w_rd_oob) begin
            if (w_wr_ok && (i_wr_base == i_rd_base)) begin
                w_rd_entry = i_wr_data;
            end else begin
                for (int w = 0; w < WORDS; w++) begin
                    w_rd_entry[w*DW +: DW] = r_mem[i_rd_base][w];
                end
            end
        end
    end

    // Read stage 1: capture a granted read, otherwise empty out when stage 2 takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else if (o_rd_gnt) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= w_rd_entry;
        end else if (w_s2_free) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Read stage 2: output register, frozen while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else if (w_s2_free) begin
            r_rd_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_rd_data <= r_s1_data;
            end
        end
    end

    // Status pulses: one cycle after the offending access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_oob <= 1'b0;
            r_wr_drop <= 1'b0;
        end else begin
            r_err_oob <= (i_wr_en && w_wr_oob) || (o_rd_gnt && w_rd_oob);
            r_wr_drop <= i_wr_en && o_ld_busy;
        end
    end

    // Loader FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Loader FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (i_ld_start) w_state_nxt = c_LOAD;
            c_LOAD:  if (w_ld_last)  w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Loader FSM outputs.
    always_comb begin
        o_ld_busy  = (r_state == c_LOAD);
        o_ld_ready = (r_state == c_LOAD);
        o_ld_done  = (r_state == c_DONE);
    end

    // Loader word counter kept as (entry, word) so no divide is needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_entry <= '0;
            r_ld_word  <= '0;
        end else if ((r_state == c_IDLE) && i_ld_start) begin
            r_ld_entry <= '0;
            r_ld_word  <= '0;
        end else if (w_ld_beat) begin
            if (r_ld_word == c_LAST_WORD) begin
                r_ld_word  <= '0;
                r_ld_entry <= (r_ld_entry == c_LAST_ENTRY) ? '0 : r_ld_entry + AW'(1);
            end else begin
                r_ld_word  <= r_ld_word + c_WW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lut_table_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_table_sync
// Purpose  : Scoreboard bench for lut_table_sync. Stimulus pushes expected
//            read entries when a read is granted; a monitor pops and compares
//            on every rd_valid && rd_ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_table_sync;

    localparam int ENTRIES = 36;
    localparam int WORDS   = 4;
    localparam int DW      = 32;
    localparam int AW      = 6;
    localparam int NW      = ENTRIES * WORDS;
    localparam int EW      = WORDS * DW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           i_wr_en = 1'b0;
    logic [AW-1:0]  i_wr_base = '0;
    logic [EW-1:0]  i_wr_data = '0;
    logic           i_rd_req = 1'b0;
    logic [AW-1:0]  i_rd_base = '0;
    logic           o_rd_gnt;
    logic           o_rd_valid;
    logic           i_rd_ready = 1'b1;
    logic [EW-1:0]  o_rd_data;
    logic           i_ld_start = 1'b0;
    logic           i_ld_valid = 1'b0;
    logic [DW-1:0]  i_ld_data = '0;
    logic           o_ld_ready;
    logic           o_ld_busy;
    logic           o_ld_done;
    logic           o_err_oob;
    logic           o_wr_drop;

    lut_table_sync #(.ENTRIES(ENTRIES), .WORDS(WORDS), .DW(DW), .AW(AW)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (i_wr_en),
        .i_wr_base  (i_wr_base),
        .i_wr_data  (i_wr_data),
        .i_rd_req   (i_rd_req),
        .i_rd_base  (i_rd_base),
        .o_rd_gnt   (o_rd_gnt),
        .o_rd_valid (o_rd_valid),
        .i_rd_ready (i_rd_ready),
        .o_rd_data  (o_rd_data),
        .i_ld_start (i_ld_start),
        .i_ld_valid (i_ld_valid),
        .i_ld_data  (i_ld_data),
        .o_ld_ready (o_ld_ready),
        .o_ld_busy  (o_ld_busy),
        .o_ld_done  (o_ld_done),
        .o_err_oob  (o_err_oob),
        .o_wr_drop  (o_wr_drop)
    );

    always #5 clk = ~clk;

    int            total = 0;
    int            bad   = 0;
    int            n_pop = 0;
    int            n_oob = 0;
    int            n_drop = 0;
    int            n_done = 0;
    logic [EW-1:0] exp_q [$];
    logic [EW-1:0] model [ENTRIES];
    logic          tog_en = 1'b0;
    logic [3:0]    pat = 4'b1001;

    task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack4(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                                            input logic [DW-1:0] w2, input logic [DW-1:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consumer-ready driver: either held high or cycling 1,0,0,1.
    initial begin
        int k = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tog_en) begin
                i_rd_ready = pat[k];
                k = (k + 1) % 4;
            end else begin
                i_rd_ready = 1'b1;
            end
        end
    end

    // Monitor: pulse counting, stall stability and scoreboard pops.
    initial begin
        logic          stall_pend = 1'b0;
        logic [EW-1:0] stall_data = '0;
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_pend = 1'b0;
            end else begin
                if (o_err_oob) n_oob++;
                if (o_wr_drop) n_drop++;
                if (o_ld_done) n_done++;
                if (stall_pend) begin
                    chk("stall_valid", EW'(o_rd_valid), EW'(1));
                    chk("stall_data", o_rd_data, stall_data);
                end
                if (o_rd_valid && i_rd_ready) begin
                    n_pop++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", o_rd_data, 'x);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_data", o_rd_data, e);
                    end
                end
                stall_pend = o_rd_valid && !i_rd_ready;
                stall_data = o_rd_data;
            end
        end
    end

    // Hold a read request until granted, then record its expected entry.
    task automatic issue_rd(input int base);
        int t = 0;
        i_rd_req  = 1'b1;
        i_rd_base = AW'(base);
        forever begin
            @(negedge clk);
            if (o_rd_gnt) begin
                exp_q.push_back((base < ENTRIES) ? model[base] : '0);
                tick();
                return;
            end
            t++;
            if (t > 100) begin
                chk("grant_timeout", EW'(0), EW'(1));
                tick();
                return;
            end
            tick();
        end
    endtask

    task automatic drain();
        int t = 0;
        i_rd_req = 1'b0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", EW'(exp_q.size()), EW'(0));
        tick();
    endtask

    task automatic check_reset_vals();
        chk("rst_rd_valid", EW'(o_rd_valid), EW'(0));
        chk("rst_rd_data",  o_rd_data,       EW'(0));
        chk("rst_ld_busy",  EW'(o_ld_busy),  EW'(0));
        chk("rst_ld_ready", EW'(o_ld_ready), EW'(0));
        chk("rst_ld_done",  EW'(o_ld_done),  EW'(0));
        chk("rst_err_oob",  EW'(o_err_oob),  EW'(0));
        chk("rst_wr_drop",  EW'(o_wr_drop),  EW'(0));
    endtask

    // Stream up to 'beats' loader words (value = flat index) with random gaps.
    task automatic bulk_load(input int beats, input bit drop_test);
        i_ld_start = 1'b1;
        tick();
        i_ld_start = 1'b0;
        for (int i = 0; i < beats; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            i_ld_valid = 1'b1;
            i_ld_data  = DW'(i);
            if (drop_test && i == 60) begin
                i_wr_en   = 1'b1;
                i_wr_base = AW'(2);
                i_wr_data = {4{32'hDEADBEEF}};
            end
            tick();
            i_ld_valid = 1'b0;
            i_wr_en    = 1'b0;
            model[i / WORDS][(i % WORDS)*DW +: DW] = DW'(i);
        end
    endtask

    task automatic do_write(input int base, input logic [EW-1:0] d);
        i_wr_en   = 1'b1;
        i_wr_base = AW'(base);
        i_wr_data = d;
        if (base < ENTRIES) model[base] = d;
        tick();
        i_wr_en = 1'b0;
    endtask

    initial begin
        int d0, o0, p0;
        // reset state
        repeat (2) @(negedge clk);
        check_reset_vals();
        tick();
        rst = 1'b0;
        tick();

        // full bulk load, with a write attempted mid-load
        d0 = n_done;
        o0 = n_drop;
        bulk_load(NW, 1'b1);
        repeat (3) tick();
        chk("ld_done_once", EW'(n_done - d0), EW'(1));
        chk("wr_drop_once", EW'(n_drop - o0), EW'(1));
        chk("ld_busy_after", EW'(o_ld_busy), EW'(0));
        issue_rd(35);               // word 3 must be 0x8F
        issue_rd(2);                // dropped write must not have landed
        drain();

        // write base 1 then read it; rd_valid two cycles after grant
        do_write(1, pack4(32'h01FE0000, 32'h02FFFFFB, 32'hFFFB0001, 32'hFF00FF00));
        issue_rd(1);
        i_rd_req = 1'b0;
        @(negedge clk);
        chk("lat_cycle1", EW'(o_rd_valid), EW'(0));
        @(negedge clk);
        chk("lat_cycle2", EW'(o_rd_valid), EW'(1));
        drain();

        // same-cycle write/read bypass, then back-to-back read of old entry
        i_wr_en   = 1'b1;
        i_wr_base = AW'(5);
        i_wr_data = {4{32'hAAAAAAAA}};
        model[5]  = {4{32'hAAAAAAAA}};
        issue_rd(5);
        i_wr_en = 1'b0;
        issue_rd(6);
        drain();

        // out-of-range read + write together: zeros and one err_oob pulse
        o0 = n_oob;
        i_wr_en   = 1'b1;
        i_wr_base = AW'(36);
        i_wr_data = {4{32'h55555555}};
        issue_rd(36);
        i_wr_en = 1'b0;
        drain();
        repeat (2) tick();
        chk("err_oob_once", EW'(n_oob - o0), EW'(1));
        issue_rd(0);
        drain();

        // streamed reads under toggling backpressure
        p0 = n_pop;
        tog_en = 1'b1;
        for (int b = 0; b < ENTRIES; b++) issue_rd(b);
        drain();
        tog_en = 1'b0;
        repeat (2) tick();
        chk("stream_count", EW'(n_pop - p0), EW'(ENTRIES));

        // reset after 50 load beats, then full reload
        d0 = n_done;
        bulk_load(50, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        tick();
        rst = 1'b0;
        tick();
        chk("no_done_partial", EW'(n_done - d0), EW'(0));
        bulk_load(NW, 1'b0);
        repeat (3) tick();
        chk("reload_done", EW'(n_done - d0), EW'(1));
        p0 = n_pop;
        for (int b = 0; b < ENTRIES; b++) issue_rd(b);
        drain();
        repeat (2) tick();
        chk("reload_count", EW'(n_pop - p0), EW'(ENTRIES));
        chk("queue_empty", EW'(exp_q.size()), EW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #500000;
        bad++;
        $display("FAIL global_timeout: got running expected finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
